// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - ID-stage decode/control with ID/EX register, hazard stall and MULT/DIV sequencer
//
// Purpose:
//   Decodes opcode/func into the datapath control bundle and registers it into
//   the ID/EX control register. Detects load-use hazards against its own
//   registered EX entry, sequences a multi-cycle MULT/DIV unit and inserts
//   bubbles on flush or stall.
//
// Optional feature macro: CTRL_MD_UNIT_EN
//   defined   : MULT/MULTU/DIV/DIVU/MFHI/MFLO decode, MULT/DIV busy FSM,
//               MULT/DIV hazard and ex_md_start exist.
//   undefined : those instructions decode as illegal NOPs; md_busy and
//               ex_md_start are tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid          IF/ID holds a real instruction
//   opcode, func      instr[31:26], instr[5:0]
//   rs, rt, rd        register specifiers
//   flush             squash the ID instruction (taken branch/jump)
//   stall             combinational; hold PC and IF/ID
//   ex_*              registered ID/EX control bundle
//   ex_md_start       one-cycle start pulse to the MULT/DIV unit
//   ex_illegal        unrecognised opcode/func
//   md_busy           MULT/DIV sequencer is BUSY

module pipelined_controller #(
  parameter int REGW   = 5,
  parameter int ALUOPW = 4,
  parameter int MD_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [REGW-1:0]   rs,
  input  logic [REGW-1:0]   rt,
  input  logic [REGW-1:0]   rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [ALUOPW-1:0] ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic              ex_regwrite,
  output logic              ex_writemem,
  output logic              ex_readmem,
  output logic              ex_memtoreg,
  output logic              ex_pc_jump,
  output logic [1:0]        ex_shift,
  output logic [REGW-1:0]   ex_dst,
  output logic              ex_md_start,
  output logic              ex_illegal,
  output logic              md_busy
);

  // ALU operation codes shared with the execute stage
  localparam logic [ALUOPW-1:0] ALU_NOP  = ALUOPW'(0);
  localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_ADDU = ALUOPW'(2);
  localparam logic [ALUOPW-1:0] ALU_SUB  = ALUOPW'(3);
  localparam logic [ALUOPW-1:0] ALU_SUBU = ALUOPW'(4);
  localparam logic [ALUOPW-1:0] ALU_AND  = ALUOPW'(5);
  localparam logic [ALUOPW-1:0] ALU_OR   = ALUOPW'(6);
  localparam logic [ALUOPW-1:0] ALU_NOR  = ALUOPW'(7);
  localparam logic [ALUOPW-1:0] ALU_SLL  = ALUOPW'(8);
  localparam logic [ALUOPW-1:0] ALU_SRL  = ALUOPW'(9);
  localparam logic [ALUOPW-1:0] ALU_SRA  = ALUOPW'(10);
  localparam logic [ALUOPW-1:0] ALU_SLT  = ALUOPW'(11);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
`ifdef CTRL_MD_UNIT_EN
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [ALUOPW-1:0] dec_aluop;
  logic              dec_alusrc, dec_regdst, dec_regwrite, dec_writemem;
  logic              dec_readmem, dec_memtoreg, dec_pc_jump, dec_illegal;
  logic [1:0]        dec_shift;
  logic [REGW-1:0]   dec_dst;
  logic              dec_rt_src;  // rt is read as a source operand
  logic              dec_md_op;   // MULT/MULTU/DIV/DIVU
  logic              dec_md_dep;  // instruction must wait for an idle MULT/DIV unit

  always_comb begin
    dec_aluop    = ALU_NOP;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_regwrite = 1'b0;
    dec_writemem = 1'b0;
    dec_readmem  = 1'b0;
    dec_memtoreg = 1'b0;
    dec_pc_jump  = 1'b0;
    dec_shift    = 2'd0;
    dec_dst      = '0;
    dec_illegal  = 1'b0;
    dec_rt_src   = 1'b0;
    dec_md_op    = 1'b0;
    dec_md_dep   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_regdst   = 1'b1;
        dec_regwrite = 1'b1;
        dec_dst      = rd;
        dec_rt_src   = 1'b1;
        case (func)
          F_ADD:  dec_aluop = ALU_ADD;
          F_ADDU: dec_aluop = ALU_ADDU;
          F_SUB:  dec_aluop = ALU_SUB;
          F_SUBU: dec_aluop = ALU_SUBU;
          F_AND:  dec_aluop = ALU_AND;
          F_OR:   dec_aluop = ALU_OR;
          F_NOR:  dec_aluop = ALU_NOR;
          F_SLT:  dec_aluop = ALU_SLT;
          F_SLL:  begin dec_aluop = ALU_SLL; dec_shift = 2'd1; end
          F_SRL:  begin dec_aluop = ALU_SRL; dec_shift = 2'd1; end
          F_SRA:  begin dec_aluop = ALU_SRA; dec_shift = 2'd1; end
          F_JR:   begin dec_pc_jump = 1'b1; dec_regwrite = 1'b0; end
`ifdef CTRL_MD_UNIT_EN
          F_MFHI, F_MFLO: dec_md_dep = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            dec_regwrite = 1'b0;
            dec_md_op    = 1'b1;
            dec_md_dep   = 1'b1;
          end
`endif
          default: begin
            dec_regdst   = 1'b0;
            dec_regwrite = 1'b0;
            dec_dst      = '0;
            dec_rt_src   = 1'b0;
            dec_illegal  = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_aluop = ALU_ADD; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
      end
      OP_LW, OP_LBU, OP_LHU: begin
        dec_aluop = ALU_ADD; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
        dec_readmem = 1'b1; dec_memtoreg = 1'b1;
      end
      OP_ANDI: begin
        dec_aluop = ALU_AND; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
      end
      OP_ORI: begin
        dec_aluop = ALU_OR; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
      end
      OP_SLTI, OP_SLTIU: begin
        dec_aluop = ALU_SLT; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
      end
      OP_LUI: begin
        dec_aluop = ALU_ADD; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_dst = rt;
        dec_shift = 2'd2;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_aluop = ALU_ADD; dec_alusrc = 1'b1; dec_writemem = 1'b1; dec_dst = rt;
        dec_rt_src = 1'b1;
      end
      OP_BEQ, OP_BNE: dec_rt_src = 1'b1;
      OP_J:   dec_pc_jump = 1'b1;
      OP_JAL: begin
        dec_pc_jump = 1'b1; dec_regwrite = 1'b1; dec_dst = REGW'(31);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazards and stall
  // ---------------------------------------------------------------------------
  logic ex_valid_q, ex_readmem_q;
  logic [REGW-1:0] ex_dst_q;
  logic lu_haz, md_haz, issue;

  assign lu_haz = ex_valid_q & ex_readmem_q & (ex_dst_q != '0) &
                  ((ex_dst_q == rs) | (dec_rt_src & (ex_dst_q == rt)));

`ifdef CTRL_MD_UNIT_EN
  assign md_haz = md_busy & dec_md_dep;
`else
  assign md_haz = 1'b0;
`endif

  // flush wins over stall: a squashed instruction never holds the front end
  assign stall = id_valid & ~flush & (lu_haz | md_haz);
  assign issue = id_valid & ~flush & ~stall;

  // ---------------------------------------------------------------------------
  // ID/EX control register
  // ---------------------------------------------------------------------------
  logic [ALUOPW-1:0] ex_aluop_q, ex_aluop_d;
  logic              ex_valid_d, ex_readmem_d;
  logic              ex_alusrc_q, ex_alusrc_d, ex_regdst_q, ex_regdst_d;
  logic              ex_regwrite_q, ex_regwrite_d, ex_writemem_q, ex_writemem_d;
  logic              ex_memtoreg_q, ex_memtoreg_d, ex_pc_jump_q, ex_pc_jump_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [1:0]        ex_shift_q, ex_shift_d;
  logic [REGW-1:0]   ex_dst_d;

  always_comb begin
    ex_valid_d    = issue;
    ex_aluop_d    = issue ? dec_aluop : ALU_NOP;
    ex_alusrc_d   = issue & dec_alusrc;
    ex_regdst_d   = issue & dec_regdst;
    ex_regwrite_d = issue & dec_regwrite;
    ex_writemem_d = issue & dec_writemem;
    ex_readmem_d  = issue & dec_readmem;
    ex_memtoreg_d = issue & dec_memtoreg;
    ex_pc_jump_d  = issue & dec_pc_jump;
    ex_illegal_d  = issue & dec_illegal;
    ex_shift_d    = issue ? dec_shift : 2'd0;
    ex_dst_d      = issue ? dec_dst : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_aluop_q    <= '0;
      ex_alusrc_q   <= 1'b0;
      ex_regdst_q   <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_writemem_q <= 1'b0;
      ex_readmem_q  <= 1'b0;
      ex_memtoreg_q <= 1'b0;
      ex_pc_jump_q  <= 1'b0;
      ex_illegal_q  <= 1'b0;
      ex_shift_q    <= 2'd0;
      ex_dst_q      <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_aluop_q    <= ex_aluop_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_regdst_q   <= ex_regdst_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_writemem_q <= ex_writemem_d;
      ex_readmem_q  <= ex_readmem_d;
      ex_memtoreg_q <= ex_memtoreg_d;
      ex_pc_jump_q  <= ex_pc_jump_d;
      ex_illegal_q  <= ex_illegal_d;
      ex_shift_q    <= ex_shift_d;
      ex_dst_q      <= ex_dst_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_aluop    = ex_aluop_q;
  assign ex_alusrc   = ex_alusrc_q;
  assign ex_regdst   = ex_regdst_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_writemem = ex_writemem_q;
  assign ex_readmem  = ex_readmem_q;
  assign ex_memtoreg = ex_memtoreg_q;
  assign ex_pc_jump  = ex_pc_jump_q;
  assign ex_illegal  = ex_illegal_q;
  assign ex_shift    = ex_shift_q;
  assign ex_dst      = ex_dst_q;

  // ---------------------------------------------------------------------------
  // MULT/DIV sequencer
  // ---------------------------------------------------------------------------
`ifdef CTRL_MD_UNIT_EN
  localparam int CNTW = $clog2(MD_LAT + 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  md_state_e       md_state_q, md_state_d;
  logic [CNTW-1:0] md_cnt_q, md_cnt_d;
  logic            ex_md_start_q, ex_md_start_d;
  logic            md_accept;

  assign md_accept     = issue & dec_md_op & (md_state_q == MD_IDLE);
  assign ex_md_start_d = md_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_q    <= MD_IDLE;
      md_cnt_q      <= '0;
      ex_md_start_q <= 1'b0;
    end else begin
      md_state_q    <= md_state_d;
      md_cnt_q      <= md_cnt_d;
      ex_md_start_q <= ex_md_start_d;
    end
  end

  // The accept cycle itself counts toward occupancy, so BUSY lasts MD_LAT-1
  // cycles: cnt runs MD_LAT-1 down to 1 while BUSY and IDLE is re-entered as
  // cnt reaches 0. With MD_LAT=1 BUSY is never entered.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (md_accept && (MD_LAT > 1)) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = CNTW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        md_cnt_d = (md_cnt_q == '0) ? '0 : md_cnt_q - CNTW'(1);
        if (md_cnt_q <= CNTW'(1)) md_state_d = MD_IDLE;
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy     = (md_state_q == MD_BUSY);
    ex_md_start = ex_md_start_q;
  end
`else
  assign md_busy     = 1'b0;
  assign ex_md_start = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// tb/tb_pipelined_controller.sv - directed scoreboard bench for pipelined_controller

module tb_pipelined_controller;

  localparam logic [3:0] A_NOP = 4'd0;
  localparam logic [3:0] A_ADD = 4'd1;
  localparam logic [3:0] A_SUB = 4'd3;
  localparam logic [3:0] A_SLL = 4'd8;

  typedef struct packed {
    logic       valid;
    logic [3:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       writemem;
    logic       readmem;
    logic       memtoreg;
    logic       pc_jump;
    logic [1:0] shift;
    logic [4:0] dst;
    logic       md_start;
    logic       illegal;
  } bundle_t;

  logic       clk, rst, id_valid, flush;
  logic [5:0] opcode, func;
  logic [4:0] rs, rt, rd;
  logic       stall, ex_valid, ex_alusrc, ex_regdst, ex_regwrite, ex_writemem;
  logic       ex_readmem, ex_memtoreg, ex_pc_jump, ex_md_start, ex_illegal, md_busy;
  logic [3:0] ex_aluop;
  logic [1:0] ex_shift;
  logic [4:0] ex_dst;

  int errors = 0;
  int checks = 0;
  bundle_t exp_q[$];

  pipelined_controller #(.REGW(5), .ALUOPW(4), .MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite), .ex_writemem(ex_writemem),
    .ex_readmem(ex_readmem), .ex_memtoreg(ex_memtoreg), .ex_pc_jump(ex_pc_jump),
    .ex_shift(ex_shift), .ex_dst(ex_dst), .ex_md_start(ex_md_start),
    .ex_illegal(ex_illegal), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [3:0] aluop, input logic alusrc, regdst,
                                 regwrite, writemem, readmem, memtoreg, pc_jump,
                                 input logic [1:0] shift, input logic [4:0] dst,
                                 input logic md_start, illegal);
    bundle_t b;
    b = '{1'b1, aluop, alusrc, regdst, regwrite, writemem, readmem, memtoreg,
          pc_jump, shift, dst, md_start, illegal};
    return b;
  endfunction

  function automatic bundle_t observed();
    bundle_t b;
    b = {ex_valid, ex_aluop, ex_alusrc, ex_regdst, ex_regwrite, ex_writemem,
         ex_readmem, ex_memtoreg, ex_pc_jump, ex_shift, ex_dst, ex_md_start, ex_illegal};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline step: drive ID at negedge, check stall, queue the expected
  // ID/EX content, then pop and compare it after the clock edge.
  task automatic step(input string tag, input logic v, input logic [5:0] op, fn,
                      input logic [4:0] s, t, d, input logic fl, input logic exp_stall,
                      input bundle_t exp_b, input logic exp_busy);
    bundle_t e;
    @(negedge clk);
    id_valid = v; opcode = op; func = fn; rs = s; rt = t; rd = d; flush = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    exp_q.push_back(exp_b);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".ex"}, 32'(observed()), 32'(e));
    chk({tag, ".busy"}, 32'(md_busy), 32'(exp_busy));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ex"}, 32'(observed()), 32'd0);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".busy"}, 32'(md_busy), 32'd0);
  endtask

  bundle_t b_add3, b_add6, b_lw5, b_lw7, b_lw10, b_lw0, b_ill;

  initial begin
    b_add3 = mk(A_ADD, 0, 1, 1, 0, 0, 0, 0, 2'd0, 5'd3, 0, 0);
    b_add6 = mk(A_ADD, 0, 1, 1, 0, 0, 0, 0, 2'd0, 5'd6, 0, 0);
    b_lw5  = mk(A_ADD, 1, 0, 1, 0, 1, 1, 0, 2'd0, 5'd5, 0, 0);
    b_lw7  = mk(A_ADD, 1, 0, 1, 0, 1, 1, 0, 2'd0, 5'd7, 0, 0);
    b_lw10 = mk(A_ADD, 1, 0, 1, 0, 1, 1, 0, 2'd0, 5'd10, 0, 0);
    b_lw0  = mk(A_ADD, 1, 0, 1, 0, 1, 1, 0, 2'd0, 5'd0, 0, 0);
    b_ill  = mk(A_NOP, 0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 0, 1);

    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    opcode = 6'h00; func = 6'h00; rs = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // ADD $3,$1,$2
    step("add", 1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 0, 0, b_add3, 0);

    // asynchronous reset mid-cycle with ADD sitting in ID
    @(negedge clk);
    id_valid = 1'b1; opcode = 6'h00; func = 6'h20; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    #2 rst = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step("add_after_rst", 1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 0, 0, b_add3, 0);

    // load-use through rs: one stall cycle, bubble, then issue
    step("lw5", 1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 0, 0, b_lw5, 0);
    step("lu_rs", 1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 0, 1, '0, 0);
    step("lu_rs_issue", 1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 0, 0, b_add6, 0);

    // load-use through rt of an R-type
    step("lw7", 1, 6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 0, 0, b_lw7, 0);
    step("lu_rt", 1, 6'h00, 6'h22, 5'd2, 5'd7, 5'd8, 0, 1, '0, 0);
    step("lu_rt_issue", 1, 6'h00, 6'h22, 5'd2, 5'd7, 5'd8, 0, 0,
         mk(A_SUB, 0, 1, 1, 0, 0, 0, 0, 2'd0, 5'd8, 0, 0), 0);

    // rt of an I-type ALU op is a destination, not a source
    step("lw10", 1, 6'h23, 6'h00, 5'd1, 5'd10, 5'd0, 0, 0, b_lw10, 0);
    step("addi_rt_dst", 1, 6'h08, 6'h00, 5'd2, 5'd10, 5'd0, 0, 0,
         mk(A_ADD, 1, 0, 1, 0, 0, 0, 0, 2'd0, 5'd10, 0, 0), 0);

    // load into $0 never creates a hazard
    step("lw0", 1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 0, 0, b_lw0, 0);
    step("r0_nohaz", 1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 0, 0, b_add6, 0);

    // store / LUI / illegal / JAL / shift / idle
    step("sw", 1, 6'h2B, 6'h00, 5'd1, 5'd5, 5'd0, 0, 0,
         mk(A_ADD, 1, 0, 0, 1, 0, 0, 0, 2'd0, 5'd5, 0, 0), 0);
    step("lui", 1, 6'h0F, 6'h00, 5'd0, 5'd4, 5'd0, 0, 0,
         mk(A_ADD, 1, 0, 1, 0, 0, 0, 0, 2'd2, 5'd4, 0, 0), 0);
    step("illegal", 1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 0, 0, b_ill, 0);
    step("jal", 1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 0, 0,
         mk(A_NOP, 0, 0, 1, 0, 0, 0, 1, 2'd0, 5'd31, 0, 0), 0);
    step("sll", 1, 6'h00, 6'h00, 5'd0, 5'd2, 5'd9, 0, 0,
         mk(A_SLL, 0, 1, 1, 0, 0, 0, 0, 2'd1, 5'd9, 0, 0), 0);
    step("idle", 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 0, 0, '0, 0);

    // store whose data register is the pending load destination
    step("lw12", 1, 6'h23, 6'h00, 5'd1, 5'd12, 5'd0, 0, 0,
         mk(A_ADD, 1, 0, 1, 0, 1, 1, 0, 2'd0, 5'd12, 0, 0), 0);
    step("lu_sw_rt", 1, 6'h2B, 6'h00, 5'd1, 5'd12, 5'd0, 0, 1, '0, 0);

    // flush beats a pending load-use stall and a MULT in ID
    step("lw5b", 1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 0, 0, b_lw5, 0);
    step("flush_mult", 1, 6'h00, 6'h18, 5'd5, 5'd2, 5'd0, 1, 0, '0, 0);
    step("after_flush", 0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0, 0, '0, 0);

`ifdef CTRL_MD_UNIT_EN
    // MULT then MFLO with MD_LAT=4: busy for 3 cycles, MFLO held 3 cycles
    step("mult", 1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 0, 0,
         mk(A_NOP, 0, 1, 0, 0, 0, 0, 0, 2'd0, 5'd0, 1, 0), 1);
    step("mflo_stall1", 1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 0, 1, '0, 1);
    step("mflo_stall2", 1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 0, 1, '0, 1);
    step("mflo_stall3", 1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 0, 1, '0, 0);
    step("mflo_issue", 1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 0, 0,
         mk(A_NOP, 0, 1, 1, 0, 0, 0, 0, 2'd0, 5'd7, 0, 0), 0);

    // reset in the middle of BUSY
    step("mult2", 1, 6'h00, 6'h1A, 5'd1, 5'd2, 5'd0, 0, 0,
         mk(A_NOP, 0, 1, 0, 0, 0, 0, 0, 2'd0, 5'd0, 1, 0), 1);
    @(negedge clk);
    id_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_state("rst_busy");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_idle", 0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0, 0, '0, 0);
`else
    // without the MULT/DIV unit these decode as illegal NOPs and never stall
    step("mult_illegal", 1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 0, 0, b_ill, 0);
    step("mflo_illegal", 1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 0, 0, b_ill, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Next-generation decode/control block in the ID stage of the 5-stage MIPS pipeline.
- Decodes opcode/func into the control bundle and registers it into the ID/EX control register.
- Owns load-use hazard detection against its own registered EX entry.
- Sequences a multi-cycle MULT/DIV unit (busy FSM); stalls dependent instructions and applies flush bubbles from the branch unit.

Parameters:
- REGW, 5, register-specifier width.
- ALUOPW, 4, ALU-op width; codes come from the shared controller constants header.
- MD_LAT, 32, MULT/DIV occupancy in cycles. Must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- opcode  in  6  instr[31:26].
- func  in  6  instr[5:0].
- rs  in  REGW  instr[25:21].
- rt  in  REGW  instr[20:16].
- rd  in  REGW  instr[15:11].
- flush  in  1  squash the ID instruction (taken branch/jump).
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  ID/EX entry is a real instruction.
- ex_aluop  out  ALUOPW  ALU operation.
- ex_alusrc, ex_regdst, ex_regwrite, ex_writemem, ex_readmem, ex_memtoreg, ex_pc_jump  out  1 each  datapath controls.
- ex_shift  out  2  1 = shamt shift, 2 = LUI.
- ex_dst  out  REGW  destination register: rd for R-type, rt for I-type, 31 for JAL.
- ex_md_start  out  1  one-cycle start pulse to the MULT/DIV unit.
- ex_illegal  out  1  unrecognised opcode/func.
- md_busy  out  1  MULT/DIV FSM in BUSY.

Behaviour:
- Decode (combinational)
  - R-type: regdst=1, regwrite=1; aluop from func (ADD, ADDU, SUB, SUBU, AND, OR, NOR, SLL, SRL, SRA, SLT).
  - JR: pc_jump=1, regwrite=0.
  - SLL/SRL/SRA: shift=1.
  - ADDI/ADDIU/LW/LBU/LHU: ALU_ADD, alusrc=1, regwrite=1. Loads also set readmem=1 and memtoreg=1 (all loads, not only LBU).
  - ANDI/ORI/SLTI/SLTIU: AND/OR/SLT, alusrc=1, regwrite=1, readmem=0.
  - LUI: ALU_ADD, alusrc=1, regwrite=1, shift=2, readmem=0.
  - SB/SH/SW: ALU_ADD, alusrc=1, writemem=1, regwrite=0.
  - BEQ/BNE: ALU_NOP, all writes 0.
  - J: pc_jump=1. JAL: pc_jump=1, regwrite=1, dst=31.
  - Anything else: NOP bundle with illegal=1. Every output is assigned on every path.
- Load-use hazard (lu_haz)
  - Condition: ex_valid & ex_readmem & ex_dst != 0 & (ex_dst == rs, or ex_dst == rt where rt is a source).
  - rt is a source for R-type, stores, BEQ and BNE.
- MULT/DIV hazard (md_haz)
  - Condition: md_busy & ID instruction is MFHI, MFLO, MULT, MULTU, DIV or DIVU.
- Stall
  - stall = id_valid & ~flush & (lu_haz | md_haz).
- ID/EX register (posedge, 1-cycle latency)
  - If flush, stall or ~id_valid: load a bubble (ex_valid=0, every control 0, ex_dst=0).
  - Otherwise load the decoded bundle with ex_valid=1.
  - flush has priority over stall.
- MULT/DIV FSM, states IDLE and BUSY
  - Accept condition: a MULT/MULTU/DIV/DIVU is accepted (not stalled, not flushed, id_valid) in IDLE.
  - On accept: ex_md_start=1 for one cycle, go to BUSY, cnt = MD_LAT-1.
  - MD_LAT=1: no BUSY cycle (FSM stays IDLE).
  - In BUSY: cnt decrements each cycle; at cnt==0 return to IDLE. md_busy is therefore high for exactly MD_LAT-1 cycles.
  - cnt width is clog2(MD_LAT+1). It never wraps; saturates at 0.
  - flush does not abort an in-progress BUSY.
- Reset (asynchronous, any time, including mid-BUSY)
  - All ex_* outputs 0, state IDLE, cnt 0, md_busy 0.
  - stall is then 0 unless a fresh lu_haz exists; none can, since ex_valid=0.

Optional Feature:
- Macro: CTRL_MD_UNIT_EN.
- Defined: MULT/DIV decode, the FSM, md_haz and ex_md_start exist as described above.
- Undefined:
  - MULT/MULTU/DIV/DIVU/MFHI/MFLO decode as illegal NOPs.
  - No FSM registers; md_busy and ex_md_start tied 0; md_haz=0.

Test Plan:
- Reset: assert rst mid-cycle with ADD in ID -> all ex_* = 0 immediately, stall=0; after release, ADD $3,$1,$2 -> next edge ex_valid=1, ex_regdst=1, ex_regwrite=1, ex_dst=3, ex_aluop=ALU_ADD.
- Load-use: LW $5,0($1), then ADD $6,$5,$2 -> stall=1 for exactly 1 cycle, bubble (ex_valid=0), then ADD issues; the same with rs=$0, rt=$0 dst -> no stall.
- Store/LUI decode: SW -> ex_writemem=1, ex_regwrite=0; LUI $4 -> ex_shift=2, ex_readmem=0, ex_dst=4.
- MULT/DIV (MD_LAT=4): MULT, then MFLO -> ex_md_start pulses once; md_busy high for 3 cycles; MFLO stalled 3 cycles, then issues.
- Flush priority: flush=1 with LW load-use pending and MULT in ID -> stall=0, bubble loaded, ex_md_start=0, FSM stays IDLE.
- Illegal: opcode 0x3F -> ex_valid=1, ex_illegal=1, ex_regwrite=0, ex_writemem=0.
